mux4_scan_ctrl: RTL and testbench
=================================

# mux4_scan_ctrl

Sequencer that sits directly upstream and downstream of the gate-level 4:1 mux. It drives the mux select lines `s1`/`s0` through channels 0..3, holds each selection for a programmable dwell time so the gate network settles, and samples the mux output `y` once per channel into a 4-bit snapshot register. A start/busy/done handshake lets a controller request one full scan and read back all four data inputs as a parallel word.

## Interface
Parameters:
- `DWELL`, default 2: cycles each select value is held. Legal range is 1..255; DWELL = 0 is illegal and the bench must not use it.
- `CW`, default 8: dwell-counter width. Must satisfy `2**CW > DWELL`.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  scan request, sampled only in IDLE.
- `y_in`  in  1  mux output `y`.
- `s0`  out  1  select LSB, driven to mux `s0`. Registered.
- `s1`  out  1  select MSB, driven to mux `s1`. Registered.
- `busy`  out  1  high while a scan is in progress (SCAN state).
- `done`  out  1  one-cycle pulse after the scan completes.
- `sample`  out  4  snapshot; `sample[c]` = `y_in` captured while select = c.

## Operation
- FSM states: IDLE, SCAN, DONE. Encoding is 2-bit binary.
- IDLE:
  - `busy` = 0, `done` = 0, select = 0.
  - `start` = 1 at an edge: go to SCAN with channel `ch` = 0 and counter `cnt` = 0.
- SCAN:
  - `busy` = 1; `{s1,s0}` = `ch`. The select is held constant for exactly DWELL cycles per channel.
  - `cnt` increments every edge. When `cnt` == DWELL-1, that edge does all of the following:
    - captures `y_in` into `sample[ch]`;
    - clears `cnt`;
    - increments `ch`.
  - The capture edge with `ch` == 3 goes to DONE. `ch` wraps to 0 and `{s1,s0}` returns to 0.
- DONE:
  - Lasts exactly one cycle: `done` = 1, `busy` = 0.
  - `start` is ignored in this state.
  - The next edge goes to IDLE.
- `sample` is updated only at capture edges. Bits not yet captured in the current scan keep their previous-scan values. `sample` is stable from DONE until the next scan overwrites it.
- `start` in SCAN or DONE is ignored; requests are not queued.
- Reset (asserted at any time, including mid-scan):
  - immediately clears state to IDLE;
  - clears `ch`, `cnt`, `s1`, `s0`, `busy`, `done` and `sample` to 0;
  - the partial scan is discarded.
  - After reset deasserts, the first rising edge with `start` = 1 begins a fresh scan.

## Timing
- Reset values: `s0` = 0, `s1` = 0, `busy` = 0, `done` = 0, `sample` = 4'b0000.
- Let edge 0 be the edge at which `start` is accepted.
  - Channel c is selected during the cycles after edges c·DWELL through (c+1)·DWELL − 1.
  - `y_in` is captured at edge (c+1)·DWELL.
  - `y_in` must be stable in the cycle before its capture edge.
- DONE is entered at edge 4·DWELL, so `done` is high for the cycle after that edge. `busy` is high during the cycles after edges 0 through 4·DWELL − 1.
- Start-to-done latency is 4·DWELL cycles.
- Minimum start-to-start spacing is 4·DWELL + 2 edges (SCAN, plus one DONE cycle, plus one IDLE edge).
- DWELL = 1: the select changes every cycle, and capture occurs on every edge in SCAN.
- The mux is combinational and is assumed to settle within one clock. DWELL ≥ 2 gives margin.

## Structure
- Shared include file `mux4_scan_defs.vh` holds the state encodings (IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2) and the default DWELL.
- One natural sub-module, `dwell_counter`: a CW-bit counter with `clr` and `inc` inputs and a terminal-count output `tc` (`cnt` == DWELL-1). It takes the same `clk`/`rst_n`.
- The top level contains the FSM, the `ch` register, select decode to `s1`/`s0`, and the `sample` capture.
- The bench instantiates `mux_4x1` with `s0`/`s1`/`y` wired to this block, so the loop is closed at gate level.

## Test plan
- Reset then idle: hold `rst_n` low for 3 cycles, then high with `start` = 0 for 10 cycles. Required: all outputs stay 0 and select stays 0.
- Basic scan, DWELL = 2, mux data d3..d0 = 1001, one-cycle `start`:
  - `busy` is high for 8 cycles;
  - `done` pulses exactly at cycle 9 after edge 0;
  - `sample` = 4'b1001;
  - select sequence is 0,0,1,1,2,2,3,3.
- Back-to-back requests:
  - `start` held high continuously with d = 0110. Required: `sample` = 0110, a `done` pulse every 10 cycles, and no restart during DONE.
  - `start` pulsed mid-scan. Required: the pulse is ignored.
- DWELL = 1 with d = 1110:
  - select changes every cycle;
  - `done` is asserted in the cycle after edge 4;
  - `sample` = 4'b1110.
- Reset mid-scan:
  - first run a scan with d = 1111 so that `sample` = 1111;
  - start a new scan with d = 0000 and assert `rst_n` low after channel 1 is captured;
  - required: `sample` = 0000 immediately, `busy` = 0 and select = 0 asynchronously;
  - a following full scan with d = 1010 gives `sample` = 1010.
- Data change during dwell, DWELL = 3:
  - toggle d0 in the first selected cycle of channel 0, then hold it stable (d0 = 1) through the capture edge;
  - required: `sample[0]` = 1, showing that only the capture-edge value counts.

Source files
------------

// File: rtl/mux4_scan_ctrl_pkg.sv
// mux4_scan_ctrl_pkg: shared state encoding and default dwell for the 4:1 mux scan sequencer.
`default_nettype none

package mux4_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DWELL_DEFAULT = 2;

endpackage

`default_nettype wire

// File: rtl/mux4_scan_ctrl_dwell_counter.sv
// dwell_counter: CW-bit up counter with synchronous clear; tc flags the last cycle of a dwell.
`default_nettype none

module dwell_counter #(
  parameter int DWELL = 2,
  parameter int CW    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam logic [CW-1:0] TC_VAL = CW'(DWELL - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tc = (cnt == TC_VAL);

endmodule

`default_nettype wire

// File: rtl/mux_4x1.sv
// mux_4x1: gate-level 4:1 multiplexer scanned by mux4_scan_ctrl.
`default_nettype none

module mux_4x1 (
  input  wire d0,
  input  wire d1,
  input  wire d2,
  input  wire d3,
  input  wire s0,
  input  wire s1,
  output wire y
);

  wire ns0, ns1, a0, a1, a2, a3;

  not u_ns0 (ns0, s0);
  not u_ns1 (ns1, s1);
  and u_a0  (a0, d0, ns1, ns0);
  and u_a1  (a1, d1, ns1, s0);
  and u_a2  (a2, d2, s1, ns0);
  and u_a3  (a3, d3, s1, s0);
  or  u_y   (y, a0, a1, a2, a3);

endmodule

`default_nettype wire

// File: rtl/mux4_scan_ctrl.sv
// mux4_scan_ctrl: steps a 4:1 mux through channels 0..3, dwelling DWELL cycles on each,
// and captures the mux output into a 4-bit snapshot with a start/busy/done handshake.
`default_nettype none

module mux4_scan_ctrl
  import mux4_scan_ctrl_pkg::*;
#(
  parameter int DWELL = DWELL_DEFAULT,
  parameter int CW    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y_in,
  output logic       s0,
  output logic       s1,
  output logic       busy,
  output logic       done,
  output logic [3:0] sample
);

  state_t     state;
  logic [1:0] ch;
  logic       tc;
  logic       cnt_clr;
  logic       cnt_inc;

  // Counter sits at zero outside SCAN so the first dwell after start is full length.
  assign cnt_inc = (state == ST_SCAN);
  assign cnt_clr = (state != ST_SCAN) || tc;

  dwell_counter #(
    .DWELL (DWELL),
    .CW    (CW)
  ) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .tc    (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ch       <= 2'd0;
      {s1, s0} <= 2'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sample   <= 4'b0000;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state    <= ST_SCAN;
            ch       <= 2'd0;
            {s1, s0} <= 2'd0;
            busy     <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (tc) begin
            sample[ch] <= y_in;
            ch         <= ch + 2'd1;
            {s1, s0}   <= ch + 2'd1;
            if (ch == 2'd3) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mux4_scan_ctrl.sv
// tb_mux4_scan_ctrl: three scan controllers (DWELL 2, 1, 3) each closing the loop through a gate-level mux.
`default_nettype none

module tb_mux4_scan_ctrl;

  typedef struct {
    int         k;
    logic [3:0] smp;
  } exp_t;

  logic       clk;
  logic       rst_n   [3];
  logic       start   [3];
  logic [3:0] dat     [3];
  logic       s0_w    [3];
  logic       s1_w    [3];
  logic       y_w     [3];
  logic       busy_w  [3];
  logic       done_w  [3];
  logic [3:0] smp_w   [3];

  exp_t sb_q[$];
  int   n_checks;
  int   n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar i = 0; i < 3; i++) begin : g_dut
    localparam int D = (i == 0) ? 2 : ((i == 1) ? 1 : 3);

    mux4_scan_ctrl #(
      .DWELL (D),
      .CW    (8)
    ) u_dut (
      .clk    (clk),
      .rst_n  (rst_n[i]),
      .start  (start[i]),
      .y_in   (y_w[i]),
      .s0     (s0_w[i]),
      .s1     (s1_w[i]),
      .busy   (busy_w[i]),
      .done   (done_w[i]),
      .sample (smp_w[i])
    );

    mux_4x1 u_mux (
      .d0 (dat[i][0]),
      .d1 (dat[i][1]),
      .d2 (dat[i][2]),
      .d3 (dat[i][3]),
      .s0 (s0_w[i]),
      .s1 (s1_w[i]),
      .y  (y_w[i])
    );
  end

  function automatic int dwell_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 3);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One full scan on instance k with cycle-exact select/busy/done checks.
  // hold keeps start high throughout; mid pulses start during SCAN; glitch wiggles d0 in channel 0's first cycle.
  task automatic scan(input int k, input logic [3:0] data, input bit hold, input bit mid, input bit glitch);
    int   dw;
    exp_t e;
    dw = dwell_of(k);
    dat[k] = glitch ? (data ^ 4'b0001) : data;
    sb_q.push_back('{k: k, smp: data});
    start[k] = 1'b1;
    @(negedge clk);
    if (!hold) start[k] = 1'b0;
    for (int i = 0; i < 4 * dw; i++) begin
      check($sformatf("sel[%0d] c%0d", k, i), 32'({s1_w[k], s0_w[k]}), 32'(i / dw));
      check($sformatf("busy[%0d] c%0d", k, i), 32'(busy_w[k]), 32'd1);
      check($sformatf("done[%0d] c%0d", k, i), 32'(done_w[k]), 32'd0);
      if (glitch && i == 0) begin
        dat[k] = data;
        #1 dat[k] = data ^ 4'b0001;
        #1 dat[k] = data;
      end
      if (mid && i == 1) start[k] = 1'b1;
      if (mid && i == 2) start[k] = 1'b0;
      @(negedge clk);
    end
    check($sformatf("done_pulse[%0d]", k), 32'(done_w[k]), 32'd1);
    check($sformatf("busy_off[%0d]", k), 32'(busy_w[k]), 32'd0);
    check($sformatf("sel_wrap[%0d]", k), 32'({s1_w[k], s0_w[k]}), 32'd0);
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check($sformatf("sample[%0d]", e.k), 32'(smp_w[e.k]), 32'(e.smp));
    end
    @(negedge clk);
    check($sformatf("idle_after_done[%0d]", k), 32'({busy_w[k], done_w[k]}), 32'd0);
    check($sformatf("sample_hold[%0d]", k), 32'(smp_w[k]), 32'(data));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0;
      start[k] = 1'b0;
      dat[k]   = 4'b0000;
    end

    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({s1_w[0], s0_w[0], busy_w[0], done_w[0], smp_w[0]}), 32'd0);
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++)
        check($sformatf("idle[%0d] c%0d", k, c),
              32'({s1_w[k], s0_w[k], busy_w[k], done_w[k], smp_w[k]}), 32'd0);
    end

    // Basic scan, DWELL = 2
    scan(0, 4'b1001, 1'b0, 1'b0, 1'b0);

    // Back-to-back with start held high, then a mid-scan pulse that must be ignored
    scan(0, 4'b0110, 1'b1, 1'b0, 1'b0);
    scan(0, 4'b0110, 1'b0, 1'b0, 1'b0);
    scan(0, 4'b1100, 1'b0, 1'b1, 1'b0);

    // DWELL = 1
    scan(1, 4'b1110, 1'b0, 1'b0, 1'b0);

    // Reset mid-scan after channel 1 capture
    scan(0, 4'b1111, 1'b0, 1'b0, 1'b0);
    dat[0]   = 4'b0000;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (4) @(negedge clk);
    check("partial_sample", 32'(smp_w[0]), 32'b1100);
    check("partial_busy", 32'(busy_w[0]), 32'd1);
    check("partial_sel", 32'({s1_w[0], s0_w[0]}), 32'd2);
    #1 rst_n[0] = 1'b0;
    #1;
    check("async_rst_sample", 32'(smp_w[0]), 32'd0);
    check("async_rst_busy", 32'(busy_w[0]), 32'd0);
    check("async_rst_sel", 32'({s1_w[0], s0_w[0]}), 32'd0);
    check("async_rst_done", 32'(done_w[0]), 32'd0);
    @(negedge clk);
    rst_n[0] = 1'b1;
    @(negedge clk);
    scan(0, 4'b1010, 1'b0, 1'b0, 1'b0);

    // DWELL = 3 with d0 disturbed early in channel 0's dwell
    scan(2, 4'b0101, 1'b0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
